pc_sequencer: RTL and testbench
===============================

# pc_sequencer

Program-counter sequencer on the fetch side of the single-cycle CPU datapath. It owns the architectural PC register, drives the fetch address into the datapath every cycle, and takes back the combinationally computed next address: PC+4, branch target or jump target. It adds run control (start/stall), halt detection, address-fault trapping and retired-instruction/cycle counters, so a testbench or top level can run a program to completion without an external PC loop.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000: PC loaded on reset and on every start.
- IMEM_BYTES, 1024: instruction memory size in bytes; a legal PC satisfies pc < IMEM_BYTES.
- MAX_INSTR, 32'd100000: watchdog limit on retired instructions.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  begin (or restart) execution from RESET_PC.
- stall  in  1  hold the PC this cycle.
- next_addr  in  32  next address computed by the datapath for the current pc_addr.
- pc_addr  out  32  registered fetch address to the datapath.
- exec_en  out  1  state==RUN && !stall; the top level gates register-file and data-memory write enables with it.
- halted  out  1  state==HALT.
- fault  out  1  state==FAULT.
- watchdog  out  1  HALT was entered because of MAX_INSTR; sticky until start.
- fault_addr  out  32  offending next_addr latched on fault entry.
- retired  out  32  instructions retired since the last start.
- cycles  out  32  clocks spent in RUN since the last start.

## Operation
- States: IDLE, RUN, HALT, FAULT.
- Reset (async, rst_n=0): state=IDLE, pc_addr=RESET_PC, retired=0, cycles=0, fault_addr=0, watchdog=0. exec_en, halted and fault are 0.
- IDLE: exec_en=0. start=1 moves to RUN.
- start in IDLE, HALT or FAULT: pc_addr<=RESET_PC, counters and watchdog cleared, fault_addr held, state<=RUN. start in RUN is ignored.
- RUN, stall=1: pc_addr, retired and state hold. cycles increments.
- RUN, stall=0: one instruction retires. Checks are evaluated in priority order:
  1. Fault: next_addr[1:0]!=0 or next_addr>=IMEM_BYTES. State<=FAULT, fault_addr<=next_addr, pc_addr holds, retired increments.
  2. Self-loop: next_addr==pc_addr (e.g. j to itself). State<=HALT, pc_addr holds, retired increments.
  3. Watchdog: retired+1==MAX_INSTR. pc_addr<=next_addr, retired increments, state<=HALT, watchdog<=1.
  4. Otherwise: pc_addr<=next_addr, retired increments.
- In RUN, cycles increments every clock regardless of stall.
- HALT and FAULT are sticky until start or reset. In both, exec_en=0, so instructions are not re-executed.
- Counters saturate at 32'hFFFF_FFFF and do not wrap.

## Timing
- pc_addr is registered. next_addr is consumed in the same cycle it is presented (combinational path through IM/Control/ALU into this block).
- exec_en, halted and fault are decoded combinationally from the state register plus stall. There are no other combinational input-to-output paths.
- First instruction: start sampled at edge N. State is RUN from edge N. Instruction at RESET_PC executes in cycle N..N+1, and pc_addr updates at edge N+1.
- Halt/fault latency: detected in the executing cycle. halted/fault are asserted after the following edge.
- Reset mid-RUN: immediate return to IDLE. Reset deassertion is assumed synchronized externally.

## Structure
- Shared package cpu_pkg holds:
  - the seq_state_t enum (IDLE, RUN, HALT, FAULT);
  - the 32-bit word/address width constant;
  - the default RESET_PC.
- One sub-module, sat_counter: 32-bit saturating counter with clr and inc inputs and async active-low reset. It is instantiated twice, for retired and cycles.

## Test plan
- Reset then start, with next_addr always pc+4 and 3 instructions before a self-jump at 0x0C: pc_addr goes 0,4,8,C, then halted=1, retired=4, cycles=4.
- stall=1 for 2 cycles at pc 0x4: pc_addr holds 0x4 and exec_en=0 for 2 cycles, retired unchanged, cycles +2.
- next_addr=0x6 (misaligned) at pc 0x8: fault=1, fault_addr=0x6, pc_addr stays 0x8, retired counts the instruction.
- next_addr=IMEM_BYTES (0x400): fault=1, fault_addr=0x400. A subsequent start gives pc_addr=RESET_PC, state RUN, retired=0.
- MAX_INSTR=5 with an endless pc+4 stream: halted=1, watchdog=1, retired=5, pc_addr=0x14.
- rst_n low mid-RUN at pc 0x10: pc_addr=0 and state IDLE immediately, without waiting for a clock edge. Start after release restarts cleanly.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU datapath definitions: word width, default reset vector and
// the PC sequencer state encoding.
package cpu_pkg;

   localparam int XLEN = 32;

   localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      HALT  = 2'd2,
      FAULT = 2'd3
   } seq_state_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; it sticks at all-ones
// instead of wrapping.
module sat_counter
   import cpu_pkg::*;
#(
   parameter int W = XLEN
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         clr,
   input  logic         inc,
   output logic [W-1:0] count
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (clr) begin
         count <= '0;
      end else if (inc && (count != '1)) begin
         count <= count + 1'b1;
      end
   end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch-side PC sequencer: owns the PC, applies the datapath's next address
// and adds run control, halt/fault detection, watchdog and counters.
module pc_sequencer
   import cpu_pkg::*;
#(
   parameter logic [XLEN-1:0] RESET_PC   = DEFAULT_RESET_PC,
   parameter int              IMEM_BYTES = 1024,
   parameter logic [XLEN-1:0] MAX_INSTR  = 32'd100000
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            start,
   input  logic            stall,
   input  logic [XLEN-1:0] next_addr,
   output logic [XLEN-1:0] pc_addr,
   output logic            exec_en,
   output logic            halted,
   output logic            fault,
   output logic            watchdog,
   output logic [XLEN-1:0] fault_addr,
   output logic [XLEN-1:0] retired,
   output logic [XLEN-1:0] cycles
);

   localparam logic [XLEN-1:0] IMEM_LIMIT = XLEN'(IMEM_BYTES);

   seq_state_t      state_q, state_d;
   logic [XLEN-1:0] pc_d, fault_addr_d;
   logic            watchdog_d;
   logic            restart, retire, bad_addr, wd_hit;

   assign bad_addr = (next_addr[1:0] != 2'b00) || (next_addr >= IMEM_LIMIT);
   // Widened compare so a saturated retired count cannot alias to zero.
   assign wd_hit   = ({1'b0, retired} + 33'd1) == {1'b0, MAX_INSTR};

   always_comb begin
      state_d      = state_q;
      pc_d         = pc_addr;
      fault_addr_d = fault_addr;
      watchdog_d   = watchdog;
      restart      = 1'b0;
      retire       = 1'b0;
      case (state_q)
         RUN: begin
            if (!stall) begin
               retire = 1'b1;
               if (bad_addr) begin
                  state_d      = FAULT;
                  fault_addr_d = next_addr;
               end else if (next_addr == pc_addr) begin
                  state_d = HALT;
               end else begin
                  pc_d = next_addr;
                  if (wd_hit) begin
                     state_d    = HALT;
                     watchdog_d = 1'b1;
                  end
               end
            end
         end
         default: begin
            if (start) begin
               restart    = 1'b1;
               state_d    = RUN;
               pc_d       = RESET_PC;
               watchdog_d = 1'b0;
            end
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         pc_addr    <= RESET_PC;
         fault_addr <= '0;
         watchdog   <= 1'b0;
      end else begin
         state_q    <= state_d;
         pc_addr    <= pc_d;
         fault_addr <= fault_addr_d;
         watchdog   <= watchdog_d;
      end
   end

   assign exec_en = (state_q == RUN) && !stall;
   assign halted  = (state_q == HALT);
   assign fault   = (state_q == FAULT);

   sat_counter #(.W(XLEN)) u_retired (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (restart),
      .inc   (retire),
      .count (retired)
   );

   sat_counter #(.W(XLEN)) u_cycles (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (restart),
      .inc   (state_q == RUN),
      .count (cycles)
   );

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: directed scenarios then random programs,
// checked against a transaction-level model of the sequencer.
module tb_pc_sequencer;

   localparam logic [31:0] RST_PC = 32'h0000_0000;
   localparam int          IMEM   = 1024;
   localparam logic [31:0] MAXI   = 32'd24;

   localparam int S_IDLE = 0, S_RUN = 1, S_HALT = 2, S_FAULT = 3;

   logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0, stall = 1'b0;
   logic [31:0] next_addr = '0;
   logic [31:0] pc_addr, fault_addr, retired, cycles;
   logic        exec_en, halted, fault, watchdog;

   pc_sequencer #(.RESET_PC(RST_PC), .IMEM_BYTES(IMEM), .MAX_INSTR(MAXI)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .stall      (stall),
      .next_addr  (next_addr),
      .pc_addr    (pc_addr),
      .exec_en    (exec_en),
      .halted     (halted),
      .fault      (fault),
      .watchdog   (watchdog),
      .fault_addr (fault_addr),
      .retired    (retired),
      .cycles     (cycles)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        exec;
      logic [31:0] pc, fa, ret, cyc;
      logic        halted, fault, wd;
   } exp_t;

   exp_t q[$];

   int          m_st  = S_IDLE;
   logic [31:0] m_pc  = RST_PC, m_fa = '0, m_ret = '0, m_cyc = '0;
   logic        m_wd  = 1'b0;
   int          n_vec = 0, n_err = 0;

   function automatic logic [31:0] sat(input logic [31:0] v);
      return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
   endfunction

   task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
      end
   endtask

   task automatic chk1(input string name, input logic act, input logic exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s at %0t: got %b, expected %b", name, $time, act, exp);
      end
   endtask

   // One clock of stimulus; the model advances and its prediction is queued.
   task automatic step(input logic s, input logic st, input logic [31:0] na);
      exp_t        e;
      logic [31:0] old_ret;
      @(negedge clk);
      start = s; stall = st; next_addr = na;
      e.exec = (m_st == S_RUN) && !st;
      if (s && m_st != S_RUN) begin
         m_st = S_RUN; m_pc = RST_PC; m_ret = '0; m_cyc = '0; m_wd = 1'b0;
      end else if (m_st == S_RUN) begin
         m_cyc = sat(m_cyc);
         if (!st) begin
            old_ret = m_ret;
            m_ret   = sat(m_ret);
            if ((na % 4) != 0 || na >= 32'(IMEM)) begin
               m_st = S_FAULT; m_fa = na;
            end else if (na == m_pc) begin
               m_st = S_HALT;
            end else begin
               m_pc = na;
               if (64'(old_ret) + 64'd1 == 64'(MAXI)) begin
                  m_st = S_HALT; m_wd = 1'b1;
               end
            end
         end
      end
      e.pc = m_pc; e.fa = m_fa; e.ret = m_ret; e.cyc = m_cyc;
      e.halted = (m_st == S_HALT); e.fault = (m_st == S_FAULT); e.wd = m_wd;
      q.push_back(e);
   endtask

   // Reset asserted between clock edges; outputs must react without a clock.
   task automatic async_reset();
      @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      chk32("rst_pc", pc_addr, RST_PC);
      chk1("rst_exec", exec_en, 1'b0);
      chk1("rst_halted", halted, 1'b0);
      chk1("rst_fault", fault, 1'b0);
      chk32("rst_retired", retired, 32'd0);
      chk32("rst_cycles", cycles, 32'd0);
      chk1("rst_wd", watchdog, 1'b0);
      chk32("rst_faddr", fault_addr, 32'd0);
      m_st = S_IDLE; m_pc = RST_PC; m_fa = '0; m_ret = '0; m_cyc = '0; m_wd = 1'b0;
      @(negedge clk);
      start = 1'b0; stall = 1'b0;
      rst_n = 1'b1;
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         #2;
         if (q.size() > 0) begin
            e = q[0];
            chk1("exec_en", exec_en, e.exec);
            @(posedge clk);
            #1;
            e = q.pop_front();
            chk32("pc_addr", pc_addr, e.pc);
            chk1("halted", halted, e.halted);
            chk1("fault", fault, e.fault);
            chk1("watchdog", watchdog, e.wd);
            chk32("fault_addr", fault_addr, e.fa);
            chk32("retired", retired, e.ret);
            chk32("cycles", cycles, e.cyc);
         end
      end
   end

   initial begin : timeout
      #2_000_000;
      $display("FAIL timeout: simulation still running at %0t, expected completion", $time);
      $fatal(1, "timeout");
   end

   initial begin : stim
      int r;
      logic [31:0] na;
      #3;
      chk32("reset_pc", pc_addr, RST_PC);
      chk1("reset_halted", halted, 1'b0);
      chk1("reset_fault", fault, 1'b0);
      chk1("reset_exec", exec_en, 1'b0);
      chk32("reset_retired", retired, 32'd0);
      chk32("reset_cycles", cycles, 32'd0);
      #2 rst_n = 1'b1;

      // Straight-line run ending in a self-jump at 0x0C.
      step(1'b1, 1'b0, m_pc + 4);
      repeat (3) step(1'b0, 1'b0, m_pc + 4);
      step(1'b0, 1'b0, m_pc);
      repeat (2) step(1'b0, 1'b0, m_pc + 4);

      // Stall at 0x4, then a misaligned target at 0x8.
      step(1'b1, 1'b0, 32'h0);
      step(1'b0, 1'b0, m_pc + 4);
      repeat (2) step(1'b0, 1'b1, m_pc + 4);
      step(1'b0, 1'b0, m_pc + 4);
      step(1'b0, 1'b0, 32'h6);
      step(1'b0, 1'b0, m_pc + 4);

      // Out-of-range target, then restart.
      step(1'b1, 1'b0, 32'h0);
      step(1'b0, 1'b0, 32'(IMEM));
      step(1'b1, 1'b0, m_pc + 4);
      step(1'b0, 1'b0, m_pc + 4);
      step(1'b1, 1'b0, m_pc + 4);

      // Endless pc+4 stream trips the watchdog.
      step(1'b1, 1'b0, 32'h0);
      repeat (30) step(1'b0, 1'b0, m_pc + 4);

      // Reset mid-run at 0x10, then clean restart.
      step(1'b1, 1'b0, 32'h0);
      repeat (4) step(1'b0, 1'b0, m_pc + 4);
      async_reset();
      step(1'b1, 1'b0, 32'h0);
      repeat (3) step(1'b0, 1'b0, m_pc + 4);

      // Random programs.
      for (int i = 0; i < 1500; i++) begin
         r = $urandom_range(0, 99);
         if (r < 4)       na = m_pc + $urandom_range(1, 3);
         else if (r < 8)  na = 32'(IMEM) + {$urandom_range(0, 63), 2'b00};
         else if (r < 13) na = m_pc;
         else if (r < 30) na = {22'd0, 8'($urandom_range(0, 255)), 2'b00};
         else             na = m_pc + 4;
         if ($urandom_range(0, 199) == 0) begin
            async_reset();
         end else begin
            step((m_st != S_RUN) ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 19) == 0),
                 $urandom_range(0, 4) == 0, na);
         end
      end

      repeat (3) @(posedge clk);
      #2;
      n_vec++;
      if (q.size() != 0) begin
         n_err++;
         $display("FAIL drain: %0d predictions left unchecked, expected 0", q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
